inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit of the NPC core. It owns the PC, issues one instruction-memory read at a time over a valid/ready request channel, and presents each returned 32-bit instruction with its PC to the decode stage, which slices the instruction into the immediate generator. Control-flow redirects from execute flush any in-flight or held instruction.

## Interface
- `RESET_PC`, 64'h8000_0000: PC fetched first after reset.
- `XLEN`, 64: PC/address width.

- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  XLEN  fetch address, always 4-byte aligned.
- `imem_rsp_valid`  in  1  read data valid, one pulse per accepted request.
- `imem_rsp_data`  in  32  instruction word.
- `id_valid`  out  1  instruction available to decode.
- `id_ready`  in  1  decode accepts instruction.
- `id_inst`  out  32  instruction word, bits [31:7] feed the immediate generator.
- `id_pc`  out  XLEN  PC of `id_inst`.
- `redirect_valid`  in  1  branch/jump taken, one-cycle pulse.
- `redirect_pc`  in  XLEN  new fetch target.
- `fetch_fault`  out  1  misaligned redirect (present only with the macro below).

## Operation
- States: REQ (drive request), WAIT (request accepted, awaiting response), HOLD (instruction held for decode), FAULT (macro only).
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc. Handshake (`valid&&ready`) -> WAIT. Address and valid stay stable until handshake.
- WAIT: on `imem_rsp_valid`, register data into `id_inst`, `id_pc`<=pc -> HOLD. If kill flag set, drop data, clear kill -> REQ.
- HOLD: `id_valid`=1. On `id_ready`: pc<=pc+4 -> REQ.
- Redirect (any state): pc<=`redirect_pc`; has priority over pc+4.
  - REQ, no handshake same cycle: request re-driven with new pc next cycle (permitted deviation from stability since the pending request is abandoned before acceptance). Handshake same cycle: set kill -> WAIT.
  - WAIT: set kill; the response is discarded; next REQ uses redirected pc. If `imem_rsp_valid` same cycle, discard it -> REQ directly.
  - HOLD: `id_valid` drops next cycle -> REQ. Redirect with `id_ready` same cycle: instruction counts as consumed, pc = `redirect_pc` (not pc+4).
- At most one outstanding memory request; responses arrive in order.
- pc arithmetic modulo 2^XLEN; pc+4 wraps silently from all-ones.

## Timing
- Reset values: `imem_req_valid`=0, `id_valid`=0, `id_inst`=32'h0000_0013 (nop), `id_pc`=`RESET_PC`, `imem_req_addr`=`RESET_PC`, `fetch_fault`=0, state REQ, kill 0.
- First cycle after `rst_n` release: `imem_req_valid`=1, address `RESET_PC`.
- Response -> `id_valid`: 1 cycle (registered).
- Best-case throughput with ready memory and 1-cycle response: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect -> new-target request on bus: next cycle from REQ/HOLD; after kill response from WAIT.
- Reset mid-operation: immediate return to reset values; pending response after reset is ignored (state REQ never samples `imem_rsp_valid`).

## Configuration
- `INST_FETCH_MISALIGN_CHK_EN` defined: redirect with `redirect_pc[1:0]`!=0 -> FAULT; `fetch_fault`=1 sticky until reset; no further requests, `id_valid`=0. Any in-flight response is dropped.
- Undefined: no `fetch_fault` port; `redirect_pc[1:0]` forced to 2'b00.

## Structure
- Shared package: state enum (REQ/WAIT/HOLD/FAULT), `RESET_PC` default, nop encoding 32'h0000_0013, XLEN constant.
- Single module; no sub-module. PC register, kill flag and output register live inline.

## Test plan
- Reset release, memory always ready, 1-cycle response, decode always ready -> requests at 8000_0000, 8000_0004, 8000_0008 every 3 cycles; `id_pc` matches each.
- `imem_req_ready` low 4 cycles -> `imem_req_addr` holds 8000_0000, `imem_req_valid` stays high, no state advance.
- Redirect to 8000_0100 while in WAIT -> stale response dropped, `id_valid` never asserts for it, next request 8000_0100.
- `id_ready` low 5 cycles in HOLD -> `id_inst`/`id_pc` stable, no new request; redirect+`id_ready` same cycle -> next request at `redirect_pc`.
- pc=FFFF_FFFF_FFFF_FFFC, accept -> next request 0.
- With macro, redirect to 8000_0102 -> `fetch_fault`=1 next cycle, no further `imem_req_valid` until `rst_n` low.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared constants and types for the NPC instruction fetch unit.
//   XLEN_DEF      : default PC/address width
//   RESET_PC_DEF  : default first fetch address after reset
//   NOP_INST      : addi x0,x0,0, the decode-side value before any fetch
//   fetch_state_e : fetch FSM state encoding
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

   localparam int          XLEN_DEF     = 64;
   localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch unit: owns the PC, issues one instruction-memory read at a
// time and holds each returned word (with its PC) for the decode stage.
// Redirects from execute flush any in-flight or held instruction.
//
// Optional feature macro: INST_FETCH_MISALIGN_CHK_EN
//   defined   : misaligned redirect target -> sticky fetch_fault, fetch stops
//   undefined : no fetch_fault port, redirect_pc[1:0] treated as 2'b00
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   imem_req_*        request channel (valid/ready, 4-byte aligned address)
//   imem_rsp_*        response (one pulse per accepted request, in order)
//   id_valid/ready    decode handshake; id_inst/id_pc held instruction + PC
//   redirect_valid/pc control-flow redirect from execute (one-cycle pulse)
//   fetch_fault       misaligned redirect flag (macro builds only)
//
// state | meaning
// REQ   | request driven on bus, waiting for imem_req_ready
// WAIT  | request accepted, waiting for imem_rsp_valid
// HOLD  | instruction presented to decode, waiting for id_ready
// FAULT | misaligned redirect seen, fetch halted until reset
// -----------------------------------------------------------------------------
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int               XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [31:0]     id_inst,
   output logic [XLEN-1:0] id_pc,
   input  logic            redirect_valid,
`ifdef INST_FETCH_MISALIGN_CHK_EN
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_fault
`else
   input  logic [XLEN-1:0] redirect_pc
`endif
);

   localparam logic [XLEN-1:0] PC_INC     = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   fetch_state_e    r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc, w_pc_nxt;
   logic            r_kill, w_kill_nxt;
   logic            r_started;
   logic [31:0]     r_id_inst;
   logic [XLEN-1:0] r_id_pc;
   logic            w_load_id;
   logic            w_hs;
   logic            w_misalign;
   logic [XLEN-1:0] w_redirect_tgt;

`ifdef INST_FETCH_MISALIGN_CHK_EN
   assign w_redirect_tgt = redirect_pc;
   assign w_misalign     = (redirect_pc[1:0] != 2'b00);
   assign fetch_fault    = (r_state == ST_FAULT);
`else
   assign w_redirect_tgt = redirect_pc & ALIGN_MASK;
   assign w_misalign     = 1'b0;
`endif

   // r_started keeps the request low through reset and opens it on the first
   // clock edge after release.
   assign imem_req_valid = r_started && (r_state == ST_REQ);
   assign imem_req_addr  = r_pc;
   assign w_hs           = imem_req_valid && imem_req_ready;
   assign id_valid       = (r_state == ST_HOLD);
   assign id_inst        = r_id_inst;
   assign id_pc          = r_id_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_REQ;
         r_pc      <= RESET_PC;
         r_kill    <= 1'b0;
         r_started <= 1'b0;
         r_id_inst <= NOP_INST;
         r_id_pc   <= RESET_PC;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_kill    <= w_kill_nxt;
         r_started <= 1'b1;
         if (w_load_id) begin
            r_id_inst <= imem_rsp_data;
            r_id_pc   <= r_pc;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_kill_nxt  = r_kill;
      w_load_id   = 1'b0;

      case (r_state)
         ST_REQ: begin
            if (w_hs) begin
               w_state_nxt = ST_WAIT;
               // redirect while the old-pc request is accepted: its data is stale
               if (redirect_valid) w_kill_nxt = 1'b1;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               w_kill_nxt = 1'b0;
               if (r_kill || redirect_valid) begin
                  w_state_nxt = ST_REQ;
               end else begin
                  w_state_nxt = ST_HOLD;
                  w_load_id   = 1'b1;
               end
            end else if (redirect_valid) begin
               w_kill_nxt = 1'b1;
            end
         end
         ST_HOLD: begin
            if (id_ready) w_pc_nxt = r_pc + PC_INC;
            if (id_ready || redirect_valid) w_state_nxt = ST_REQ;
         end
         default: ;
      endcase

      // redirect overrides pc+4; FAULT is terminal until reset
      if (redirect_valid && (r_state != ST_FAULT)) begin
         w_pc_nxt = w_redirect_tgt;
         if (w_misalign) begin
            w_state_nxt = ST_FAULT;
            w_kill_nxt  = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [63:0] id_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
`ifdef INST_FETCH_MISALIGN_CHK_EN
   logic        fetch_fault;
`endif

   inst_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .redirect_valid (redirect_valid),
`ifdef INST_FETCH_MISALIGN_CHK_EN
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault)
`else
      .redirect_pc    (redirect_pc)
`endif
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // memory model state
   bit          mem_auto = 1'b1;
   int          rsp_lat  = 1;
   int          pend_cnt = 0;
   logic [63:0] pend_addr;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return a[31:0] ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One clock: handshake is observed before the edge, inputs update 1 time
   // unit after it, outputs are then sampled by the caller.
   task automatic tick();
      logic        hs;
      logic [63:0] a;
      hs = imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      if (mem_auto) begin
         imem_rsp_valid = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = inst_of(pend_addr);
            end
         end
         if (hs) begin
            if (rsp_lat <= 1) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = inst_of(a);
            end else begin
               pend_addr = a;
               pend_cnt  = rsp_lat - 1;
            end
         end
      end
   endtask

   typedef struct {
      logic        rr;
      logic        ir;
      logic        rv;
      logic [63:0] rpc;
      logic        e_val;
      logic [63:0] e_addr;
      logic        e_idv;
      logic [63:0] e_idpc;
   } vec_t;

   vec_t vq[$];

   initial begin
      bit seen_idv;
      // starting in REQ, pc = 8000_0000, 1-cycle memory
      for (int i = 0; i < 4; i++)
         vq.push_back('{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, RPC,       1'b0, RPC});
      vq.push_back('{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, RPC,          1'b0, RPC});
      vq.push_back('{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, RPC,          1'b1, RPC});
      vq.push_back('{1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0004, 1'b0, RPC});
      vq.push_back('{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h8000_0004, 1'b0, RPC});
      vq.push_back('{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h8000_0004, 1'b1, 64'h8000_0004});
      vq.push_back('{1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0008, 1'b0, 64'h8000_0004});
      vq.push_back('{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h8000_0008, 1'b0, 64'h8000_0004});
      // redirect in WAIT with response same cycle: dropped, straight to REQ
      vq.push_back('{1'b1, 1'b1, 1'b1, 64'h8000_0100, 1'b1, 64'h8000_0100, 1'b0, 64'h8000_0004});
      vq.push_back('{1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h8000_0100, 1'b0, 64'h8000_0004});
      vq.push_back('{1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h8000_0100, 1'b1, 64'h8000_0100});
      // decode stalls 5 cycles in HOLD
      for (int i = 0; i < 5; i++)
         vq.push_back('{1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h8000_0100, 1'b1, 64'h8000_0100});
      // redirect + id_ready together: target wins over pc+4
      vq.push_back('{1'b1, 1'b1, 1'b1, 64'h8000_0200, 1'b1, 64'h8000_0200, 1'b0, 64'h8000_0100});
      vq.push_back('{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0200, 1'b0, 64'h8000_0100});

      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
      chk("rst_req_addr", imem_req_addr, RPC);
      chk("rst_id_valid", {63'h0, id_valid}, 64'h0);
      chk("rst_id_inst", {32'h0, id_inst}, 64'h13);
      chk("rst_id_pc", id_pc, RPC);
      rst_n = 1'b1;
      tick();
      chk("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("first_req_addr", imem_req_addr, RPC);

      foreach (vq[i]) begin
         imem_req_ready = vq[i].rr;
         id_ready       = vq[i].ir;
         redirect_valid = vq[i].rv;
         redirect_pc    = vq[i].rpc;
         tick();
         chk($sformatf("v%0d_req_valid", i), {63'h0, imem_req_valid}, {63'h0, vq[i].e_val});
         chk($sformatf("v%0d_req_addr", i), imem_req_addr, vq[i].e_addr);
         chk($sformatf("v%0d_id_valid", i), {63'h0, id_valid}, {63'h0, vq[i].e_idv});
         chk($sformatf("v%0d_id_pc", i), id_pc, vq[i].e_idpc);
         if (vq[i].e_idv)
            chk($sformatf("v%0d_id_inst", i), {32'h0, id_inst}, {32'h0, inst_of(vq[i].e_idpc)});
      end

      // redirect in WAIT with a slow response: kill, then refetch target
      rsp_lat        = 3;
      imem_req_ready = 1'b1;
      tick();
      chk("kslow_wait", {63'h0, imem_req_valid}, 64'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0300;
      tick();
      seen_idv = id_valid;
      for (int i = 0; i < 10 && !imem_req_valid; i++) begin
         tick();
         if (id_valid) seen_idv = 1'b1;
      end
      chk("kslow_no_id_valid", {63'h0, seen_idv}, 64'h0);
      chk("kslow_req_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("kslow_req_addr", imem_req_addr, 64'h8000_0300);
      rsp_lat = 1;

      // redirect in REQ on the handshake cycle: accepted request is killed
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0400;
      tick();
      chk("khs_wait", {63'h0, imem_req_valid}, 64'h0);
      tick();
      chk("khs_req_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("khs_req_addr", imem_req_addr, 64'h8000_0400);
      chk("khs_id_valid", {63'h0, id_valid}, 64'h0);

      // pc wrap from FFFF_FFFF_FFFF_FFFC
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      chk("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      tick();
      tick();
      chk("wrap_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_id_inst", {32'h0, id_inst}, {32'h0, inst_of(64'hFFFF_FFFF_FFFF_FFFC)});
      tick();
      chk("wrap_req_addr0", imem_req_addr, 64'h0);
      chk("wrap_req_valid", {63'h0, imem_req_valid}, 64'h1);

      // reset while WAIT with response pending
      tick();
      mem_auto = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_req_valid", {63'h0, imem_req_valid}, 64'h0);
      chk("mrst_id_valid", {63'h0, id_valid}, 64'h0);
      chk("mrst_id_pc", id_pc, RPC);
      tick();
      rst_n          = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_req_ready = 1'b0;
      tick();
      chk("mrst_rel_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("mrst_rel_addr", imem_req_addr, RPC);
      tick();
      chk("mrst_rsp_ignored", {63'h0, id_valid}, 64'h0);
      chk("mrst_still_req", {63'h0, imem_req_valid}, 64'h1);
      imem_rsp_valid = 1'b0;
      mem_auto = 1'b1;

      // misaligned redirect
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0102;
      tick();
`ifdef INST_FETCH_MISALIGN_CHK_EN
      chk("mis_fault", {63'h0, fetch_fault}, 64'h1);
      chk("mis_req_valid", {63'h0, imem_req_valid}, 64'h0);
      imem_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mis_stop%0d", i), {62'h0, imem_req_valid, id_valid}, 64'h0);
         chk($sformatf("mis_sticky%0d", i), {63'h0, fetch_fault}, 64'h1);
      end
      rst_n = 1'b0;
      #1;
      chk("mis_rst_clear", {63'h0, fetch_fault}, 64'h0);
`else
      chk("mis_req_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("mis_req_addr", imem_req_addr, 64'h8000_0100);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
